// File: rtl/puf_soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_soc_pkg
//  Description : Shared types and constants for the PUF SoC frame path.
//                Holds the serializer state encoding, packet byte counts,
//                sync marker and the frame bit-field map shared with the
//                frame assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
package puf_soc_pkg;

  // Frame geometry and packet constants
  localparam int unsigned FRAME_W         = 160;
  localparam int unsigned LONG_BYTES      = FRAME_W / 8;
  localparam int unsigned SHORT_BYTES     = 5;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned DROP_CNT_W_DEF  = 8;

  // Frame bit-field map, kept identical to the assembler's layout
  localparam int unsigned FLD_CNT_LSER_LSB = 0;
  localparam int unsigned FLD_CNT_LSER_MSB = 31;
  localparam int unsigned FLD_CNT_0_LSB    = 32;
  localparam int unsigned FLD_CNT_0_MSB    = 63;
  localparam int unsigned FLD_CNT_1_LSB    = 64;
  localparam int unsigned FLD_CNT_1_MSB    = 95;
  localparam int unsigned FLD_FULL_0       = 96;
  localparam int unsigned FLD_FULL_1       = 97;

  // Serializer packet phases
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  // Running checksum step: plain modulo-256 addition
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_soc_frame_slot.sv
`default_nettype none
// ============================================================================
//  Module      : puf_soc_frame_slot
//  Description : Two-entry frame holder (active + pending) in front of the
//                byte serializer. Keeps frames in arrival order, drops a new
//                frame when both entries are occupied and the active packet
//                is not finishing, and keeps a saturating drop counter.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                frame_data_i/op_mode_i/frame_valid_i - incoming frame strobe
//                fsm_idle_i         - serializer is idle (no active frame)
//                pkt_done_i         - active packet's last byte transfers now
//                start_o            - a frame becomes active at this edge
//                act_data_o/act_mode_o - active frame contents
//                pend_full_o        - pending entry occupied
//                pend_full_next_o   - pending occupancy after this edge
//                drop_pulse_o       - one-cycle pulse per dropped frame
//                drop_cnt_o         - saturating dropped-frame count
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_frame_slot #(
  parameter int unsigned FRAM_SIZE  = 160,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAM_SIZE-1:0]  frame_data_i,
  input  logic                  op_mode_i,
  input  logic                  frame_valid_i,
  input  logic                  fsm_idle_i,
  input  logic                  pkt_done_i,
  output logic                  start_o,
  output logic [FRAM_SIZE-1:0]  act_data_o,
  output logic                  act_mode_o,
  output logic                  pend_full_o,
  output logic                  pend_full_next_o,
  output logic                  drop_pulse_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  logic [FRAM_SIZE-1:0]  act_data_q;
  logic                  act_mode_q;
  logic [FRAM_SIZE-1:0]  pend_data_q;
  logic                  pend_mode_q;
  logic                  pend_full_q;
  logic                  pend_full_d;
  logic                  drop_pulse_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic w_take_idle;   // idle serializer takes the new frame directly
  logic w_promote;     // pending frame moves up as the active packet ends
  logic w_direct;      // packet ends, nothing pending, new frame goes active
  logic w_park;        // new frame goes into the pending entry
  logic w_drop;        // no room for the new frame

  always_comb begin
    w_take_idle = fsm_idle_i & frame_valid_i;
    w_promote   = pkt_done_i & pend_full_q;
    w_direct    = pkt_done_i & ~pend_full_q & frame_valid_i;
    // Pending accepts when it is empty, or when it is being vacated right now.
    w_park      = frame_valid_i & ~fsm_idle_i &
                  ((~pkt_done_i & ~pend_full_q) | w_promote);
    w_drop      = frame_valid_i & ~fsm_idle_i & ~pkt_done_i & pend_full_q;
    start_o     = w_take_idle | w_promote | w_direct;
    pend_full_d = w_park | (pend_full_q & ~w_promote);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q   <= '0;
      act_mode_q   <= 1'b0;
      pend_data_q  <= '0;
      pend_mode_q  <= 1'b0;
      pend_full_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      if (w_take_idle | w_direct) begin
        act_data_q <= frame_data_i;
        act_mode_q <= op_mode_i;
      end else if (w_promote) begin
        act_data_q <= pend_data_q;
        act_mode_q <= pend_mode_q;
      end
      if (w_park) begin
        pend_data_q <= frame_data_i;
        pend_mode_q <= op_mode_i;
      end
      pend_full_q  <= pend_full_d;
      drop_pulse_q <= w_drop;
      if (w_drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  assign act_data_o       = act_data_q;
  assign act_mode_o       = act_mode_q;
  assign pend_full_o      = pend_full_q;
  assign pend_full_next_o = pend_full_d;
  assign drop_pulse_o     = drop_pulse_q;
  assign drop_cnt_o       = drop_cnt_q;

endmodule
`default_nettype wire

// File: rtl/puf_soc_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : puf_soc_frame_serializer
//  Description : Converts captured frames into byte packets on a valid/ready
//                stream: SYNC, LEN, payload bytes LSB first, CSUM. One frame
//                in flight plus one pending; overflow frames are dropped and
//                counted.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                i_op_mode                  - 1 = long packet, 0 = short
//                i_frame_data/i_frame_valid - frame and its one-cycle strobe
//                o_tx_data/o_tx_valid       - byte stream toward the UART
//                i_tx_ready                 - transmitter accepts the byte
//                o_busy                     - active or pending frame held
//                o_drop_pulse/o_drop_cnt    - drop event and saturating count
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_frame_serializer #(
  parameter int unsigned FRAM_SIZE   = puf_soc_pkg::FRAME_W,
  parameter int unsigned SHORT_BYTES = puf_soc_pkg::SHORT_BYTES,
  parameter logic [7:0]  SYNC_BYTE   = puf_soc_pkg::SYNC_BYTE_DEF,
  parameter int unsigned DROP_CNT_W  = puf_soc_pkg::DROP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_op_mode,
  input  logic [FRAM_SIZE-1:0]  i_frame_data,
  input  logic                  i_frame_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_drop_pulse,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  import puf_soc_pkg::*;

  localparam int unsigned     LONG_N     = FRAM_SIZE / 8;
  localparam int unsigned     IDX_W      = $clog2(LONG_N);
  localparam logic [7:0]      LEN_LONG   = 8'(LONG_N);
  localparam logic [7:0]      LEN_SHORT  = 8'(SHORT_BYTES);
  localparam logic [IDX_W-1:0] LAST_LONG  = IDX_W'(LONG_N - 1);
  localparam logic [IDX_W-1:0] LAST_SHORT = IDX_W'(SHORT_BYTES - 1);

  state_e           state_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             busy_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       csum_q;

  logic                 w_xfer;
  logic                 w_start;
  logic                 w_fsm_idle;
  logic                 w_pkt_done;
  logic [FRAM_SIZE-1:0] w_act_data;
  logic                 w_act_mode;
  logic                 w_pend_full;
  logic                 w_pend_full_d;
  logic [IDX_W-1:0]     w_next_idx;
  logic [IDX_W+2:0]     w_next_off;
  logic [7:0]           w_next_byte;
  logic [7:0]           w_csum_next;
  logic                 w_last;
  logic                 w_going_idle;

  assign w_xfer      = tx_valid_q & i_tx_ready;
  assign w_fsm_idle  = (state_q == ST_IDLE);
  assign w_pkt_done  = (state_q == ST_CSUM) & w_xfer;
  assign w_next_idx  = idx_q + IDX_W'(1);
  assign w_next_off  = {w_next_idx, 3'b000};
  assign w_next_byte = w_act_data[w_next_off +: 8];
  assign w_csum_next = csum_add(csum_q, tx_data_q);
  assign w_last      = (idx_q == (w_act_mode ? LAST_LONG : LAST_SHORT));
  // Serializer returns to IDLE at this edge (nothing starts, packet ends)
  assign w_going_idle = (w_fsm_idle & ~w_start) | (w_pkt_done & ~w_start);

  puf_soc_frame_slot #(
    .FRAM_SIZE  (FRAM_SIZE),
    .DROP_CNT_W (DROP_CNT_W)
  ) u_slot (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_data_i     (i_frame_data),
    .op_mode_i        (i_op_mode),
    .frame_valid_i    (i_frame_valid),
    .fsm_idle_i       (w_fsm_idle),
    .pkt_done_i       (w_pkt_done),
    .start_o          (w_start),
    .act_data_o       (w_act_data),
    .act_mode_o       (w_act_mode),
    .pend_full_o      (w_pend_full),
    .pend_full_next_o (w_pend_full_d),
    .drop_pulse_o     (o_drop_pulse),
    .drop_cnt_o       (o_drop_cnt)
  );

  // Packet FSM with registered byte/valid outputs. The byte presented in a
  // state is loaded on the transfer that enters it, so data stays stable
  // while the transmitter stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      idx_q      <= '0;
      csum_q     <= '0;
    end else begin
      // Pending occupancy implies a packet is in flight, kept explicit anyway
      busy_q <= ~w_going_idle | w_pend_full_d;
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            state_q    <= ST_SYNC;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_BYTE;
          end
        end
        ST_SYNC: begin
          if (w_xfer) begin
            state_q   <= ST_LEN;
            tx_data_q <= w_act_mode ? LEN_LONG : LEN_SHORT;
          end
        end
        ST_LEN: begin
          if (w_xfer) begin
            state_q   <= ST_PAYLOAD;
            csum_q    <= tx_data_q;       // checksum starts with LEN
            idx_q     <= '0;
            tx_data_q <= w_act_data[7:0];
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            csum_q <= w_csum_next;
            if (w_last) begin
              state_q   <= ST_CSUM;
              tx_data_q <= w_csum_next;
            end else begin
              idx_q     <= w_next_idx;
              tx_data_q <= w_next_byte;
            end
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            if (w_start) begin
              state_q   <= ST_SYNC;       // back-to-back, no idle cycle
              tx_data_q <= SYNC_BYTE;
            end else begin
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
          tx_data_q  <= '0;
        end
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;

  // Pending occupancy is only observed through the registered busy flag
  logic w_unused;
  assign w_unused = w_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_puf_soc_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_soc_frame_serializer
//  Description : Scoreboard bench. The reference model treats the device as
//                a two-packet store: accepted frames expand into their full
//                byte packet, overflow frames are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_soc_frame_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_op_mode;
  logic [159:0] i_frame_data;
  logic         i_frame_valid;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_busy;
  logic         o_drop_pulse;
  logic [7:0]   o_drop_cnt;

  always #5 clk = ~clk;

  puf_soc_frame_serializer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_op_mode     (i_op_mode),
    .i_frame_data  (i_frame_data),
    .i_frame_valid (i_frame_valid),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_drop_pulse  (o_drop_pulse),
    .o_drop_cnt    (o_drop_cnt)
  );

  int         total = 0;
  int         bad   = 0;

  // Reference model state
  logic [7:0] exp_q[$];     // bytes still to be seen on the stream
  int         pkt_left[$];  // remaining byte count of each held packet
  int         exp_cnt   = 0;
  logic       exp_pulse = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole packet for a frame: SYNC, LEN, payload LSB first, 8-bit sum of LEN+payload
  function automatic void push_pkt(input logic [159:0] d, input logic m);
    int         n;
    logic [7:0] cs;
    logic [7:0] b;
    logic [7:0] nb;
    n  = m ? 20 : 5;
    nb = n[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(nb);
    cs = nb;
    for (int k = 0; k < n; k++) begin
      b  = d[8*k +: 8];
      exp_q.push_back(b);
      cs = cs + b;
    end
    exp_q.push_back(cs);
    pkt_left.push_back(n + 3);
  endfunction

  // Monitor: checks outputs mid-cycle, then predicts the effect of the next edge
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop_pulse", o_drop_pulse, 0);
        chk("rst_drop_cnt", o_drop_cnt, 0);
        exp_q.delete();
        pkt_left.delete();
        exp_cnt    = 0;
        exp_pulse  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("busy", o_busy, pkt_left.size() != 0);
        chk("tx_valid", o_tx_valid, pkt_left.size() != 0);
        chk("drop_pulse", o_drop_pulse, exp_pulse);
        chk("drop_cnt", o_drop_cnt, exp_cnt);
        if (prev_stall) begin
          chk("hold_valid", o_tx_valid, 1);
          chk("hold_data", o_tx_data, prev_data);
        end
        exp_pulse = 1'b0;
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", o_tx_data, e);
          end
          if (pkt_left.size() != 0) begin
            pkt_left[0] = pkt_left[0] - 1;
            if (pkt_left[0] == 0) void'(pkt_left.pop_front());
          end
        end
        if (i_frame_valid) begin
          if (pkt_left.size() < 2) begin
            push_pkt(i_frame_data, i_op_mode);
          end else begin
            exp_pulse = 1'b1;
            if (exp_cnt != 255) exp_cnt++;
          end
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
      end
    end
  end

  task automatic drive(input logic v, input logic m, input logic [159:0] d, input logic r);
    i_frame_valid = v;
    i_op_mode     = m;
    i_frame_data  = d;
    i_tx_ready    = r;
    @(posedge clk);
    #1;
    i_frame_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) drive(1'b0, 1'b0, '0, r);
  endtask

  function automatic logic [159:0] rnd_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || pkt_left.size() != 0); i++)
      drive(1'b0, 1'b0, '0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] f;
    rst_n = 1'b0;
    i_op_mode = 1'b0;
    i_frame_data = '0;
    i_frame_valid = 1'b0;
    i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Short frame: A5,05,10,00,00,00,00,15
    drive(1'b1, 1'b0, 160'h10, 1'b1);
    chk("short_first_sync", o_tx_data, 8'hA5);
    drain();
    idle(2, 1'b1);

    // Long frame, byte k = k+1
    f = '0;
    for (int k = 0; k < 20; k++) f[8*k +: 8] = 8'(k + 1);
    drive(1'b1, 1'b1, f, 1'b1);
    drain();

    // Backpressure: ready pattern 1,0,0,1 repeating
    drive(1'b1, 1'b1, rnd_frame(), 1'b1);
    for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, '0, !((i % 4 == 1) || (i % 4 == 2)));
    drain();

    // Queueing: frames 1 and 2 held, frame 3 dropped
    drive(1'b1, 1'b1, rnd_frame(), 1'b1);
    idle(1, 1'b1);
    drive(1'b1, 1'b0, rnd_frame(), 1'b1);
    idle(1, 1'b1);
    drive(1'b1, 1'b1, rnd_frame(), 1'b1);
    chk("queue_drop_pulse", o_drop_pulse, 1);
    chk("queue_drop_cnt", o_drop_cnt, 1);
    drain();

    // Simultaneous: third frame arrives on the CSUM transfer of the first
    drive(1'b1, 1'b0, rnd_frame(), 1'b1);   // CSUM transfers 8 edges later
    idle(1, 1'b1);
    drive(1'b1, 1'b0, rnd_frame(), 1'b1);   // pending
    idle(5, 1'b1);
    drive(1'b1, 1'b1, rnd_frame(), 1'b1);   // lands on the CSUM transfer
    chk("simul_no_drop", o_drop_pulse, 0);
    chk("simul_cnt_kept", o_drop_cnt, 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), rnd_frame(),
            $urandom_range(0, 3) != 0);
    drain();

    // Saturation: two frames held with ready low, then 260 overflows
    drive(1'b1, 1'b1, rnd_frame(), 1'b0);
    drive(1'b1, 1'b0, rnd_frame(), 1'b0);
    for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, rnd_frame(), 1'b0);
    chk("drop_saturated", o_drop_cnt, 255);
    drain();

    // Reset while payload byte 3 is presented
    drive(1'b1, 1'b0, rnd_frame(), 1'b1);
    idle(5, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_tx_valid, 0);
    chk("async_rst_data", o_tx_data, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_cnt", o_drop_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1, 1'b1);
    drive(1'b1, 1'b0, 160'h10, 1'b1);
    chk("post_rst_sync", o_tx_data, 8'hA5);
    drain();
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puf_soc_frame_serializer.md
Name: puf_soc_frame_serializer

Overview:
- Downstream of the frame assembler. Captures each 160-bit frame on its one-cycle valid strobe.
- Turns the frame into a byte packet on a valid/ready byte stream toward the UART transmitter: SYNC, LEN, payload bytes LSB first, then CSUM.
- Holds one active frame plus one pending frame, because the assembler has no backpressure.
- Counts frames it had to drop.

Parameters:
- FRAM_SIZE, 160, input frame width; must be a multiple of 8; LONG_BYTES = FRAM_SIZE/8 = 20.
- SHORT_BYTES, 5, payload bytes sent when the captured op_mode = 0 (frame bits 39:0).
- SYNC_BYTE, 8'hA5, packet start marker.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active low.
- i_op_mode  input  1  sampled together with i_frame_valid; 1 = long packet, 0 = short packet.
- i_frame_data  input  FRAM_SIZE  frame from the assembler.
- i_frame_valid  input  1  one-cycle frame strobe.
- o_tx_data  output  8  byte toward the UART transmitter.
- o_tx_valid  output  1  byte valid.
- i_tx_ready  input  1  transmitter accepts the byte.
- o_busy  output  1  high when the active or pending frame is occupied.
- o_drop_pulse  output  1  one-cycle pulse when a frame is dropped.
- o_drop_cnt  output  DROP_CNT_W  saturating count of dropped frames.

Behaviour:
- Reset (asynchronous, any state): o_tx_data=0, o_tx_valid=0, o_busy=0, o_drop_pulse=0, o_drop_cnt=0, FSM=IDLE, both frame slots empty.
  - Reset during a packet aborts it; no partial continuation after reset.
- Handshake: a byte transfers on a cycle where o_tx_valid & i_tx_ready.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable.
  - o_tx_valid never drops without a transfer.
  - All outputs are registered.
- FSM states: IDLE, SYNC, LEN, PAYLOAD, CSUM.
  - IDLE: on i_frame_valid, load the active slot (data plus op_mode) → SYNC. o_tx_valid=1 and o_tx_data=SYNC_BYTE on the next cycle (1-cycle latency).
  - SYNC --xfer--> LEN. LEN byte = LONG_BYTES if mode=1, else SHORT_BYTES.
  - LEN --xfer--> PAYLOAD. Byte index k starts at 0; byte k = active[8k+7:8k].
  - PAYLOAD --xfer--> k+1. On the transfer of the last byte (k = LEN-1) → CSUM.
  - CSUM --xfer--> one of:
    - SYNC of the pending frame, if the pending slot is full. Back-to-back, no idle cycle.
    - SYNC of a new frame, if i_frame_valid arrives in the same cycle.
    - IDLE, with o_tx_valid=0, otherwise.
- Checksum: 8-bit sum mod 256 of the LEN byte and all payload bytes; SYNC is excluded. Accumulated on each transfer.
- Capture rules for i_frame_valid while not in IDLE:
  - Pending slot empty → store the frame in pending.
  - Pending slot full and not being consumed this cycle → drop the new frame: o_drop_pulse=1 next cycle; o_drop_cnt += 1, saturating at all-ones.
  - Pending slot being moved to active this cycle (CSUM transfer) → the new frame is written to pending; no drop.
- Pending priority: pending always goes out before any newer frame, so frames are sent in order.
- o_busy = (FSM != IDLE) | pending_full.
- In op_mode=0, bytes above SHORT_BYTES-1 are never sent.

Decomposition:
- Shared package puf_soc_pkg holds:
  - SYNC_BYTE default.
  - State enum (IDLE, SYNC, LEN, PAYLOAD, CSUM).
  - LONG_BYTES/SHORT_BYTES localparams.
  - Frame bit-field offsets shared with the assembler (cnt_lser [31:0], cnt_0 [63:32], cnt_1 [95:64], full_0 96, full_1 97).
- One natural sub-module: puf_soc_frame_slot, the 2-entry active/pending holding register with the in-order, drop and saturation logic. The FSM and byte mux stay in the top.

Test Plan:
- Short frame: op_mode=0, frame[39:0]=40'h00_0000_0010, ready held 1 → bytes A5,05,10,00,00,00,00,15 on 8 consecutive cycles starting 1 cycle after valid; then o_tx_valid=0 and o_busy=0.
- Long frame: op_mode=1, frame bytes 0x01..0x14 (byte k = k+1) → A5,14, then 01..14, then CSUM = (0x14+210) mod 256 = 0xE6.
- Backpressure: ready toggles 1,0,0,1 during payload → o_tx_data stable while ready=0; byte order and checksum are unchanged.
- Queueing and drop: three valids during the first packet, ready=1.
  - Frames 1 and 2 go out back-to-back: the SYNC of frame 2 appears the cycle after the CSUM of frame 1.
  - Frame 3 is dropped: o_drop_pulse fires once and o_drop_cnt=1.
- Simultaneous events: valid on the CSUM transfer cycle with pending full → no drop; pending is sent next and the new frame follows. Also, 260 forced drops → o_drop_cnt saturates at 255.
- Reset mid-payload: rst_n low at payload byte 3 → outputs 0 immediately. After release, a new short frame produces a clean A5 packet with the correct checksum.
